// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owner, counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of MEM grants taken while a fetch is waiting; flags when fetch must win next.
module mem_arb_starve
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             grant_if,
    input  logic             grant_mem,
    input  logic             if_req,
    input  logic             if_kill,
    input  logic [CNT_W-1:0] limit,
    output logic             limit_reached
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!if_req || grant_if) begin
            count_reg <= '0;
        end else if (grant_mem && !if_kill && (count_reg < limit)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign limit_reached = (count_reg >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the memory stage: IDLE -> ISSUE -> RESP per
// transaction, MEM-first priority bounded by a starvation limit, fetch cancellation on kill.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_done,
    output logic [DW-1:0] mem_rdata,
    output logic          port_req,
    output logic          port_we,
    output logic [AW-1:0] port_addr,
    output logic [DW-1:0] port_wdata,
    input  logic          port_ack,
    input  logic [DW-1:0] port_rdata,
    output logic          stall
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t        state_reg;
    owner_t        owner_reg;
    logic          kill_reg;
    logic          port_req_reg;
    logic          port_we_reg;
    logic [AW-1:0] port_addr_reg;
    logic [DW-1:0] port_wdata_reg;
    logic          if_done_reg;
    logic          mem_done_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] mem_rdata_reg;

    logic limit_reached;
    logic grant_mem;
    logic grant_if;

    // MEM holds the older instruction, so it wins unless fetch has already waited out the limit.
    assign grant_mem = (state_reg == ST_IDLE) && mem_req && (!if_req || !limit_reached);
    assign grant_if  = (state_reg == ST_IDLE) && !grant_mem && if_req && !if_kill;

    mem_arb_starve u_starve (
        .clk           (clk),
        .reset         (reset),
        .grant_if      (grant_if),
        .grant_mem     (grant_mem),
        .if_req        (if_req),
        .if_kill       (if_kill),
        .limit         (LIMIT),
        .limit_reached (limit_reached)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_NONE;
            kill_reg       <= 1'b0;
            port_req_reg   <= 1'b0;
            port_we_reg    <= 1'b0;
            port_addr_reg  <= '0;
            port_wdata_reg <= '0;
            if_done_reg    <= 1'b0;
            mem_done_reg   <= 1'b0;
            if_rdata_reg   <= '0;
            mem_rdata_reg  <= '0;
        end else begin
            if_done_reg  <= 1'b0;
            mem_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    kill_reg <= 1'b0;
                    if (grant_mem) begin
                        port_req_reg   <= 1'b1;
                        port_we_reg    <= mem_we;
                        port_addr_reg  <= mem_addr;
                        port_wdata_reg <= mem_wdata;
                        owner_reg      <= OWN_MEM;
                        state_reg      <= ST_ISSUE;
                    end else if (grant_if) begin
                        port_req_reg   <= 1'b1;
                        port_we_reg    <= 1'b0;
                        port_addr_reg  <= if_addr;
                        port_wdata_reg <= '0;
                        owner_reg      <= OWN_IF;
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if ((owner_reg == OWN_IF) && if_kill) begin
                        kill_reg <= 1'b1;
                    end
                    if (port_ack) begin
                        port_req_reg <= 1'b0;
                        state_reg    <= ST_RESP;
                        if (owner_reg == OWN_MEM) begin
                            mem_rdata_reg <= port_rdata;
                            mem_done_reg  <= 1'b1;
                        end else if (!(kill_reg || if_kill)) begin
                            // A cancelled fetch still finishes on the port but never reaches the pipeline.
                            if_rdata_reg <= port_rdata;
                            if_done_reg  <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    owner_reg <= OWN_NONE;
                    kill_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    owner_reg <= OWN_NONE;
                end
            endcase
        end
    end

    assign port_req   = port_req_reg;
    assign port_we    = port_we_reg;
    assign port_addr  = port_addr_reg;
    assign port_wdata = port_wdata_reg;
    assign if_done    = if_done_reg;
    assign if_rdata   = if_rdata_reg;
    assign mem_done   = mem_done_reg;
    assign mem_rdata  = mem_rdata_reg;

    assign stall = (mem_req && !mem_done) || (if_req && !if_done && !if_kill);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a request-level model of arbitration order and memory contents.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          port_req;
    logic          port_we;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_wdata;
    logic          port_ack;
    logic [DW-1:0] port_rdata;
    logic          stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_kill    (if_kill),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .port_req   (port_req),
        .port_we    (port_we),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_ack   (port_ack),
        .port_rdata (port_rdata),
        .stall      (stall)
    );

    // Behavioural memory behind the port.
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    bit            resp_en     = 1'b0;
    bit            resp_busy   = 1'b0;
    int            resp_delay  = 0;
    int            resp_jitter = 0;
    int            resp_wait   = 0;
    logic [DW-1:0] last_if_data = '0;

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Advance to the next falling edge and let the memory model react to the port.
    task automatic tick();
        @(negedge clk);
        if (port_ack) begin
            port_ack  = 1'b0;
            resp_busy = 1'b0;
        end else if (resp_en && port_req) begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                resp_wait = resp_delay + int'($urandom_range(resp_jitter, 0));
            end
            if (resp_wait == 0) begin
                port_ack   = 1'b1;
                port_rdata = mem_read(port_addr);
                if (port_we) mem_model[port_addr] = port_wdata;
            end else begin
                resp_wait--;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 0; if_addr = '0; if_kill = 0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
        port_ack = 0; port_rdata = '0;
        repeat (3) tick();
        checks++;
        if ({port_req, port_we, port_addr, port_wdata, if_done, if_rdata, mem_done, mem_rdata, stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got port_req=%b port_addr=%h if_done=%b mem_done=%b stall=%b, required all 0",
                     port_req, port_addr, if_done, mem_done, stall);
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (port_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_port_req: got %b required 0", port_req);
        end
        $display("txn reset done");
    endtask

    task automatic test_lone_fetch();
        mem_model[32'h40] = 32'h8C410004;
        resp_en = 1; resp_delay = 0; resp_jitter = 0;
        if_addr = 32'h40; if_req = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lone_stall_on_req: got %b required 1", stall);
        end
        tick();
        checks++;
        if ({port_req, port_we, port_addr} !== {1'b1, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL lone_port_issue: got req=%b we=%b addr=%h required req=1 we=0 addr=00000040",
                     port_req, port_we, port_addr);
        end
        tick();
        checks++;
        if (if_done !== 1'b1) begin
            errors++;
            $display("FAIL lone_done_latency: got if_done=%b two cycles after request, required 1", if_done);
        end
        checks++;
        if (if_rdata !== 32'h8C410004) begin
            errors++;
            $display("FAIL lone_rdata: got %h required 8c410004", if_rdata);
        end
        last_if_data = 32'h8C410004;
        if_req = 0;
        tick();
        checks++;
        if (if_done !== 1'b0) begin
            errors++;
            $display("FAIL lone_done_pulse: got if_done=%b one cycle later, required 0", if_done);
        end
        $display("txn lone fetch addr=00000040 data=%h", if_rdata);
    endtask

    task automatic test_contention();
        int   n_tx;
        int   cyc;
        bit   got_if;
        bit   stall_ok;
        logic prev_req;
        n_tx = 0; cyc = 0; got_if = 0; stall_ok = 1; prev_req = 0;
        mem_addr = 32'h100; mem_we = 1; mem_wdata = 32'hDEADBEEF; mem_req = 1;
        if_addr = 32'h40; if_req = 1;
        while (!got_if && cyc < 40) begin
            tick();
            cyc++;
            if (port_req && !prev_req) begin
                n_tx++;
                if (n_tx == 1) begin
                    checks++;
                    if ({port_we, port_addr, port_wdata} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin
                        errors++;
                        $display("FAIL contention_first_mem: got we=%b addr=%h wdata=%h required we=1 addr=00000100 wdata=deadbeef",
                                 port_we, port_addr, port_wdata);
                    end
                end else if (n_tx == 2) begin
                    checks++;
                    if ({port_we, port_addr} !== {1'b0, 32'h40}) begin
                        errors++;
                        $display("FAIL contention_second_if: got we=%b addr=%h required we=0 addr=00000040",
                                 port_we, port_addr);
                    end
                end
            end
            prev_req = port_req;
            if (mem_done) mem_req = 0;
            if (if_done) begin
                got_if = 1;
                checks++;
                if (stall !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_stall_release: got %b in if_done cycle, required 0", stall);
                end
                checks++;
                if (if_rdata !== 32'h8C410004) begin
                    errors++;
                    $display("FAIL contention_if_rdata: got %h required 8c410004", if_rdata);
                end
                if_req = 0;
            end
            #1;
            if (!got_if && stall !== 1'b1) stall_ok = 0;
        end
        checks++;
        if (!got_if || n_tx != 2) begin
            errors++;
            $display("FAIL contention_complete: got if_done_seen=%0d transactions=%0d required 1 and 2", got_if, n_tx);
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL contention_stall_held: stall dropped before if_done, required continuously 1");
        end
        $display("txn contention mem store then fetch, transactions=%0d", n_tx);
    endtask

    task automatic test_starvation();
        int            n_tx;
        int            mem_dones;
        int            cyc;
        bit            got_if;
        logic          prev_req;
        logic [AW-1:0] cur_maddr;
        n_tx = 0; mem_dones = 0; cyc = 0; got_if = 0; prev_req = 0;
        resp_delay = 0; resp_jitter = 2;
        mem_we = 0; mem_addr = 32'h200; mem_req = 1;
        if_addr = 32'h48; if_req = 1;
        while (!got_if && cyc < 200) begin
            tick();
            cyc++;
            if (port_req && !prev_req) begin
                n_tx++;
                if (n_tx == LIMIT + 1) begin
                    checks++;
                    if ({port_we, port_addr} !== {1'b0, 32'h48}) begin
                        errors++;
                        $display("FAIL starve_if_grant: transaction %0d got we=%b addr=%h required fetch at 00000048",
                                 n_tx, port_we, port_addr);
                    end
                end
            end
            prev_req = port_req;
            if (mem_done) begin
                cur_maddr = mem_addr;
                mem_dones++;
                checks++;
                if (mem_rdata !== mem_read(cur_maddr)) begin
                    errors++;
                    $display("FAIL starve_mem_rdata: addr=%h got %h required %h", cur_maddr, mem_rdata, mem_read(cur_maddr));
                end
                mem_addr = mem_addr + 32'd4;
            end
            if (if_done) begin
                got_if = 1;
                last_if_data = mem_read(32'h48);
                if_req = 0;
                mem_req = 0;
            end
        end
        checks++;
        if (!got_if || mem_dones != LIMIT) begin
            errors++;
            $display("FAIL starve_bound: got mem_done pulses=%0d before fetch (fetch served=%0d), required %0d and 1",
                     mem_dones, got_if, LIMIT);
        end
        tick();
        tick();
        $display("txn starvation mem_dones_before_fetch=%0d", mem_dones);
    endtask

    task automatic test_kill();
        bit bad_done;
        bit saw_drop;
        resp_delay = 3; resp_jitter = 0;
        if_addr = 32'h80; if_req = 1; if_kill = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL kill_stall_mask: got %b with if_kill high, required 0", stall);
        end
        tick();
        checks++;
        if (port_req !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_no_grant: got port_req=%b required 0", port_req);
        end
        if_kill = 0;
        tick();
        checks++;
        if ({port_req, port_addr} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL kill_grant_after: got req=%b addr=%h required req=1 addr=00000080", port_req, port_addr);
        end
        if_kill = 1; if_req = 0;
        bad_done = 0; saw_drop = 0;
        tick();
        if_kill = 0;
        if (if_done) bad_done = 1;
        repeat (8) begin
            tick();
            if (if_done) bad_done = 1;
            if (!port_req) saw_drop = 1;
        end
        checks++;
        if (bad_done) begin
            errors++;
            $display("FAIL kill_no_done: got if_done pulse for a killed fetch, required none");
        end
        checks++;
        if (!saw_drop) begin
            errors++;
            $display("FAIL kill_port_completes: port_req never dropped, required the killed transaction to complete");
        end
        checks++;
        if (if_rdata !== last_if_data) begin
            errors++;
            $display("FAIL kill_rdata_hold: got %h required %h", if_rdata, last_if_data);
        end
        resp_delay = 0;
        if_addr = 32'h84; if_req = 1;
        tick();
        checks++;
        if ({port_req, port_addr} !== {1'b1, 32'h84}) begin
            errors++;
            $display("FAIL kill_next_grant: got req=%b addr=%h required req=1 addr=00000084", port_req, port_addr);
        end
        tick();
        checks++;
        if (if_done !== 1'b1 || if_rdata !== mem_read(32'h84)) begin
            errors++;
            $display("FAIL kill_next_done: got done=%b data=%h required done=1 data=%h", if_done, if_rdata, mem_read(32'h84));
        end
        last_if_data = mem_read(32'h84);
        if_req = 0;
        tick();
        $display("txn kill in flight, next fetch data=%h", if_rdata);
    endtask

    task automatic test_reset_mid_issue();
        bit late_effect;
        resp_en = 0;
        mem_we = 0; mem_addr = 32'h300; mem_req = 1;
        tick();
        checks++;
        if (port_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_issue_entry: got port_req=%b required 1", port_req);
        end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({port_req, port_we, port_addr, port_wdata, if_done, if_rdata, mem_done, mem_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async_clear: got port_req=%b port_addr=%h if_rdata=%h mem_rdata=%h required all 0",
                     port_req, port_addr, if_rdata, mem_rdata);
        end
        mem_req = 0;
        tick();
        reset = 1'b0;
        tick();
        port_ack = 1'b1;
        port_rdata = 32'h12345678;
        late_effect = 0;
        repeat (4) begin
            tick();
            if (mem_done || if_done || port_req || (mem_rdata !== '0)) late_effect = 1;
        end
        checks++;
        if (late_effect) begin
            errors++;
            $display("FAIL rst_late_ack_ignored: late ack produced done=%b/%b or port_req=%b, required none",
                     mem_done, if_done, port_req);
        end
        resp_busy = 0;
        resp_en = 1;
        $display("txn reset mid-issue, late ack ignored=%0d", !late_effect);
    endtask

    task automatic test_random();
        bit            if_act, mem_act, timed_out, exp_stall;
        logic [AW-1:0] if_a, m_a;
        logic          m_we;
        logic [DW-1:0] m_wd;
        logic          prev_req;
        int            consec, owner, exp_owner, if_wait, mem_wait, n_if, n_mem;
        if_act = 0; mem_act = 0; timed_out = 0; prev_req = 0;
        consec = 0; owner = 0; if_wait = 0; mem_wait = 0; n_if = 0; n_mem = 0;
        if_a = '0; m_a = '0; m_we = 0; m_wd = '0;
        resp_delay = 0; resp_jitter = 3;
        for (int c = 0; c < 2000 && !timed_out; c++) begin
            tick();
            if (port_req && !prev_req) begin
                // 0 none, 1 fetch, 2 memory stage
                exp_owner = (mem_act && (!if_act || consec < LIMIT)) ? 2 : (if_act ? 1 : 0);
                checks++;
                if (exp_owner == 0) begin
                    errors++;
                    $display("FAIL rand_spurious_grant: port_req rose with no request pending");
                end else if (exp_owner == 2 && {port_we, port_addr, port_wdata} !== {m_we, m_a, m_wd}) begin
                    errors++;
                    $display("FAIL rand_grant_mem: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                             port_we, port_addr, port_wdata, m_we, m_a, m_wd);
                end else if (exp_owner == 1 && {port_we, port_addr, port_wdata} !== {1'b0, if_a, 32'h0}) begin
                    errors++;
                    $display("FAIL rand_grant_if: got we=%b addr=%h wdata=%h required we=0 addr=%h wdata=0",
                             port_we, port_addr, port_wdata, if_a);
                end
                owner = exp_owner;
                if (exp_owner == 2 && if_act && consec < LIMIT) consec++;
                if (exp_owner == 1) consec = 0;
            end
            prev_req = port_req;
            if (mem_done) begin
                checks++;
                if (owner != 2 || !mem_act || (!m_we && mem_rdata !== mem_read(m_a))) begin
                    errors++;
                    $display("FAIL rand_mem_done: owner=%0d addr=%h we=%b got %h required %h",
                             owner, m_a, m_we, mem_rdata, mem_read(m_a));
                end
                $display("txn rand mem we=%b addr=%h data=%h", m_we, m_a, m_we ? m_wd : mem_rdata);
                mem_act = 0; mem_req = 0; n_mem++;
            end
            if (if_done) begin
                checks++;
                if (owner != 1 || !if_act || if_rdata !== mem_read(if_a)) begin
                    errors++;
                    $display("FAIL rand_if_done: owner=%0d addr=%h got %h required %h",
                             owner, if_a, if_rdata, mem_read(if_a));
                end
                $display("txn rand fetch addr=%h data=%h", if_a, if_rdata);
                if_act = 0; if_req = 0; consec = 0; n_if++;
            end
            if (if_act) if_wait++;
            if (mem_act) mem_wait++;
            if (if_wait > 80 || mem_wait > 80) begin
                checks++;
                errors++;
                timed_out = 1;
                $display("FAIL rand_timeout: fetch waited %0d, mem waited %0d cycles, required at most 80", if_wait, mem_wait);
            end
            exp_stall = (mem_act && !mem_done) || (if_act && !if_done);
            if (!if_act && $urandom_range(2, 0) == 0) begin
                if_act = 1; if_wait = 0;
                if_a = AW'($urandom_range(31, 0)) << 2;
                if_addr = if_a; if_req = 1;
            end
            if (!mem_act && $urandom_range(1, 0) == 0) begin
                mem_act = 1; mem_wait = 0;
                m_a = AW'($urandom_range(31, 0)) << 2;
                m_we = 1'($urandom_range(1, 0));
                m_wd = DW'($urandom);
                mem_addr = m_a; mem_we = m_we; mem_wdata = m_wd; mem_req = 1;
            end
            exp_stall = exp_stall || ((if_act && !if_done) || (mem_act && !mem_done));
            #1;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL rand_stall: got %b required %b (if_act=%0d mem_act=%0d)", stall, exp_stall, if_act, mem_act);
            end
        end
        $display("txn random done fetches=%0d mem_ops=%0d", n_if, n_mem);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_kill();
        test_reset_mid_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between the instruction-fetch stage and the memory stage of the 5-stage pipeline, which share one unified instruction/data memory. Serialises requests through a three-state FSM, issues them with a variable-latency req/ack handshake, and returns data with a one-cycle done pulse. Generates the global pipeline `stall` and discards fetches cancelled by a taken branch. Priority goes to the memory stage, since it holds the older instruction, and a starvation counter bounds how long fetch can be locked out.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `STARVE_LIMIT`, 4: maximum number of consecutive MEM grants while `if_req` is waiting. Range 1–15.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `if_req`  in  1  fetch request. Held until `if_done` is seen.
- `if_addr`  in  AW  fetch address. Stable while `if_req` is high.
- `if_kill`  in  1  branch redirect. Cancels the current fetch.
- `if_done`  out  1  one-cycle pulse. `if_rdata` is valid in this cycle.
- `if_rdata`  out  DW  fetched instruction.
- `mem_req`  in  1  load/store request. Held until `mem_done` is seen.
- `mem_we`  in  1  1 selects store, 0 selects load.
- `mem_addr`  in  AW  data address.
- `mem_wdata`  in  DW  store data.
- `mem_done`  out  1  one-cycle pulse.
- `mem_rdata`  out  DW  load data. Valid while `mem_done` is high.
- `port_req`  out  1  memory port request. Registered.
- `port_we`  out  1  memory port write enable. Registered.
- `port_addr`  out  AW  memory port address. Registered.
- `port_wdata`  out  DW  memory port write data. Registered.
- `port_ack`  in  1  one-cycle transaction-complete pulse from memory.
- `port_rdata`  in  DW  read data. Valid while `port_ack` is high.
- `stall`  out  1  freeze for the IF/ID/EX/MEM pipeline registers. Combinational.

## Operation
- **Reset values.** All outputs are 0 on reset. FSM goes to IDLE, owner to NONE, starvation count to 0, kill flag to 0.
- **IDLE.** Arbitrate among current requests; the result is registered at the edge.
  - Grant MEM if `mem_req` is high and (`if_req` is low, or starvation count < `STARVE_LIMIT`).
  - Otherwise grant IF if `if_req` is high and `if_kill` is low.
  - On a grant: load `port_*` from the winner, set `port_req`=1, go to ISSUE.
  - For an IF grant, `port_we`=0 and `port_wdata`=0.
- **ISSUE.**
  - `port_*` are held constant.
  - On `port_ack`: capture `port_rdata` into the owner's rdata register, drop `port_req`, go to RESP.
  - There is no timeout.
- **RESP.** Assert the owner's done for exactly this one cycle, then return to IDLE.
  - The requester must deassert req at the edge where it sees done.
  - req being still high during RESP is ignored.
- **Kill.**
  - `if_kill` while IF owns ISSUE: the port transaction completes normally. The kill flag is set, no `if_done` is produced, and the FSM still spends one cycle in RESP.
  - `if_kill` while in IDLE: IF is not eligible for a grant that cycle.
  - The kill flag clears on entry to IDLE.
- **Starvation counter.**
  - Increments on each MEM grant while `if_req` is high and `if_kill` is low. Saturates at `STARVE_LIMIT`.
  - Clears on an IF grant, and in any cycle where `if_req` is low.
- **Stall.** `stall` = (`mem_req` & ~`mem_done`) | (`if_req` & ~`if_done` & ~`if_kill`).
- **Reset mid-transaction.** `port_req` drops asynchronously and the in-flight transaction is abandoned. The memory model must tolerate a dropped request; a late `port_ack` arriving in IDLE is ignored.
- **Simultaneous requests.** When `if_req` and `mem_req` rise in the same cycle and the counter is 0, MEM wins.
- **rdata registers.** `if_rdata` and `mem_rdata` hold their last value until the next capture.

## Timing
- Request seen at edge N → `port_req` high from cycle N+1.
- Earliest `port_ack` is in cycle N+1. That ack gives RESP and done in cycle N+2.
- Minimum request-to-done latency is therefore 2 cycles.
- Back-to-back throughput is one transaction per 3 cycles: IDLE, ISSUE, RESP.
- `port_ack` outside ISSUE is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, RESP);
  - the owner enum (NONE, IF, MEM);
  - the counter width constant, 4 bits.
- Sub-module `mem_arb_starve`: the saturating starvation counter. Inputs are grant, `if_req`, `if_kill`, and limit; output is the limit-reached flag.

## Test plan
- **Lone fetch.** `if_req` with `if_addr`=0x40; memory acks 1 cycle after `port_req` with data 0x8C410004 → `if_done` 2 cycles after the request is seen, `if_rdata`=0x8C410004, `port_we`=0.
- **Contention.** `if_req` and `mem_req` rise together; store to 0x100 with data 0xDEADBEEF → MEM is served first (`port_we`=1, `port_addr`=0x100), then IF. `stall` stays high until `if_done`.
- **Starvation bound.** `STARVE_LIMIT`=4, `mem_req` held continuously, `if_req` high → after exactly 4 `mem_done` pulses the next grant goes to IF.
- **Kill in flight.** `if_kill` pulsed while IF is in ISSUE, ack after 3 cycles → no `if_done` and `if_rdata` unchanged. The next request is granted from IDLE.
- **Reset mid-ISSUE.** Assert `reset` during ISSUE → `port_req`=0 immediately and all outputs are 0. A late `port_ack` produces no done pulse.
